// File: rtl/usr_pkg.sv
// usr_pkg: mode encoding and helpers shared by the universal shift register slice
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD,
        MODE_LOAD,
        MODE_SHR,
        MODE_SHL,
        MODE_ROR,
        MODE_ROL,
        MODE_ASR,
        MODE_CLEAR
    } mode_t;

    function automatic logic is_shift(mode_t m);
        return m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR};
    endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// universal_shift_register_if: control, parallel and serial signals of the shift register
interface universal_shift_register_if #(parameter int N = 8);
    import usr_pkg::*;

    localparam int CW = $clog2(N + 1);

    logic          en;
    mode_t         mode;
    logic          serial_in_l;
    logic          serial_in_r;
    logic [N-1:0]  parallel_in;
    logic [N-1:0]  parallel_out;
    logic          serial_out_r;
    logic          serial_out_l;
    logic [CW-1:0] shift_cnt;
    logic          frame_done;

    modport master (
        output en, mode, serial_in_l, serial_in_r, parallel_in,
        input  parallel_out, serial_out_r, serial_out_l, shift_cnt, frame_done
    );

    modport slave (
        input  en, mode, serial_in_l, serial_in_r, parallel_in,
        output parallel_out, serial_out_r, serial_out_l, shift_cnt, frame_done
    );

endinterface

// File: rtl/usr_shift_counter.sv
// usr_shift_counter: counts shift ops modulo N and pulses once on each wrap
module usr_shift_counter #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(N+1)-1:0]   cnt,
    output logic                     wrap_pulse
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          wrap_d, wrap_q;
    logic          at_last;

    assign at_last = (cnt_q == CW'(N - 1));

    // Next count: clear wins, increment wraps at N-1 so N is never reached
    always_comb begin
        cnt_d  = clr ? '0 : inc ? (at_last ? '0 : cnt_q + 1'b1) : cnt_q;
        wrap_d = inc && !clr && at_last;
    end

    // Counter and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt        = cnt_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: N-bit load/shift/rotate register with frame counter
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    universal_shift_register_if.slave     bus
);

    logic [N-1:0] q_d, q_q;

    // Datapath next state selected by mode; en=0 holds
    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            case (bus.mode)
                MODE_LOAD:  q_d = bus.parallel_in;
                MODE_SHR:   q_d = {bus.serial_in_l, q_q[N-1:1]};
                MODE_SHL:   q_d = {q_q[N-2:0], bus.serial_in_r};
                MODE_ROR:   q_d = {q_q[0], q_q[N-1:1]};
                MODE_ROL:   q_d = {q_q[N-2:0], q_q[N-1]};
                MODE_ASR:   q_d = {q_q[N-1], q_q[N-1:1]};
                MODE_CLEAR: q_d = '0;
                default:    q_d = q_q;
            endcase
        end
    end

    // Register contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    usr_shift_counter #(.N(N)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (bus.en && is_shift(bus.mode)),
        .clr        (bus.en && (bus.mode == MODE_LOAD || bus.mode == MODE_CLEAR)),
        .cnt        (bus.shift_cnt),
        .wrap_pulse (bus.frame_done)
    );

    assign bus.parallel_out = q_q;
    assign bus.serial_out_r = q_q[0];
    assign bus.serial_out_l = q_q[N-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed checks of modes, counter wrap and reset
module tb_universal_shift_register;
    import usr_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    universal_shift_register_if #(.N(8)) bus ();

    universal_shift_register #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input mode_t m, input logic sl = 1'b0,
                        input logic sr = 1'b0, input logic [7:0] pin = 8'h00);
        bus.en          = e;
        bus.mode        = m;
        bus.serial_in_l = sl;
        bus.serial_in_r = sr;
        bus.parallel_in = pin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ser_exp;
        logic [7:0] des_bits;
        ser_exp  = 8'b1011_0100;
        des_bits = 8'b1010_0111;
        bus.en          = 1'b0;
        bus.mode        = MODE_HOLD;
        bus.serial_in_l = 1'b0;
        bus.serial_in_r = 1'b0;
        bus.parallel_in = 8'h00;
        #12;
        chk("reset_q", 32'(bus.parallel_out), 32'h0);
        chk("reset_cnt", 32'(bus.shift_cnt), 32'h0);
        chk("reset_fd", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // build q=A5, cnt=3 then reset asynchronously mid-cycle
        step(1, MODE_LOAD, 0, 0, 8'hB4);
        step(1, MODE_ROL);
        step(1, MODE_ROL);
        step(1, MODE_ROL);
        chk("pre_rst_q", 32'(bus.parallel_out), 32'hA5);
        chk("pre_rst_cnt", 32'(bus.shift_cnt), 32'h3);
        chk("pre_rst_sol", 32'(bus.serial_out_l), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", 32'(bus.parallel_out), 32'h0);
        chk("async_rst_cnt", 32'(bus.shift_cnt), 32'h0);
        chk("async_rst_fd", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load + SHR serialize
        step(1, MODE_LOAD, 0, 0, 8'hB4);
        chk("ser_load_q", 32'(bus.parallel_out), 32'hB4);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser_bit%0d", i), 32'(bus.serial_out_r), 32'(ser_exp[i]));
            step(1, MODE_SHR, 0);
            chk($sformatf("ser_fd%0d", i), 32'(bus.frame_done), (i == 7) ? 32'h1 : 32'h0);
        end
        chk("ser_q", 32'(bus.parallel_out), 32'h0);
        chk("ser_cnt", 32'(bus.shift_cnt), 32'h0);
        step(1, MODE_HOLD);
        chk("ser_fd_after", 32'(bus.frame_done), 32'h0);

        // deserialize via SHL, first bit ends up at MSB
        step(1, MODE_CLEAR);
        for (int i = 0; i < 8; i++) begin
            step(1, MODE_SHL, 0, des_bits[7-i]);
            chk($sformatf("des_fd%0d", i), 32'(bus.frame_done), (i == 7) ? 32'h1 : 32'h0);
        end
        chk("des_q", 32'(bus.parallel_out), 32'hA7);
        // en=0 right after a wrap still drops the pulse
        step(0, MODE_SHL);
        chk("des_fd_en0", 32'(bus.frame_done), 32'h0);

        // rotate / ASR
        step(1, MODE_LOAD, 0, 0, 8'h81);
        step(1, MODE_ROL);
        chk("rol_q", 32'(bus.parallel_out), 32'h03);
        step(1, MODE_ROR);
        chk("ror1_q", 32'(bus.parallel_out), 32'h81);
        step(1, MODE_ROR);
        chk("ror2_q", 32'(bus.parallel_out), 32'hC0);
        step(1, MODE_ASR, 0);
        chk("asr_q", 32'(bus.parallel_out), 32'hE0);
        chk("rot_cnt", 32'(bus.shift_cnt), 32'h4);
        chk("rot_fd", 32'(bus.frame_done), 32'h0);

        // enable gating
        step(1, MODE_LOAD, 0, 0, 8'h3C);
        for (int i = 0; i < 5; i++) step(0, MODE_SHR, 1);
        chk("en0_q", 32'(bus.parallel_out), 32'h3C);
        chk("en0_cnt", 32'(bus.shift_cnt), 32'h0);
        chk("en0_fd", 32'(bus.frame_done), 32'h0);
        step(1, MODE_CLEAR);
        chk("clear_q", 32'(bus.parallel_out), 32'h0);

        // wrap / restart
        for (int i = 0; i < 7; i++) step(1, MODE_SHR, 1);
        chk("wr_cnt7", 32'(bus.shift_cnt), 32'h7);
        chk("wr_fd7", 32'(bus.frame_done), 32'h0);
        chk("wr_q7", 32'(bus.parallel_out), 32'hFE);
        step(1, MODE_LOAD, 0, 0, 8'hFF);
        chk("wr_load_cnt", 32'(bus.shift_cnt), 32'h0);
        chk("wr_load_fd", 32'(bus.frame_done), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1, MODE_SHL, 0, 0);
            chk($sformatf("wr_a_fd%0d", i), 32'(bus.frame_done), (i == 7) ? 32'h1 : 32'h0);
        end
        chk("wr_a_q", 32'(bus.parallel_out), 32'h00);
        for (int i = 0; i < 8; i++) begin
            step(1, MODE_SHL, 0, 1);
            chk($sformatf("wr_b_fd%0d", i), 32'(bus.frame_done), (i == 7) ? 32'h1 : 32'h0);
        end
        chk("wr_b_q", 32'(bus.parallel_out), 32'hFF);
        step(1, MODE_LOAD, 0, 0, 8'h5A);
        chk("post_wrap_load_q", 32'(bus.parallel_out), 32'h5A);
        chk("post_wrap_load_cnt", 32'(bus.shift_cnt), 32'h0);
        chk("post_wrap_load_fd", 32'(bus.frame_done), 32'h0);
        chk("post_wrap_sol", 32'(bus.serial_out_l), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised N-bit shift register; next generation of the team's serial/parallel shift register.
- Adds bidirectional shift, rotate, arithmetic shift, synchronous clear and a clock-enable.
- Adds a shift counter with a one-cycle frame-done pulse, so a serializer/deserializer controller can tell when N bits have moved.
- Sits between a parallel datapath and single-bit serial links.

Parameters:
- N, 8, register width in bits; legal N >= 2.
- CW, $clog2(N+1), shift-counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  operation enable; 0 = hold everything.
- mode  input  3  operation select (mode_t, see Behaviour).
- serial_in_l  input  1  bit entering the MSB on logical shift right.
- serial_in_r  input  1  bit entering the LSB on shift left.
- parallel_in  input  N  parallel load data.
- parallel_out  output  N  register contents q.
- serial_out_r  output  1  q[0], combinational.
- serial_out_l  output  1  q[N-1], combinational.
- shift_cnt  output  CW  shifts/rotates performed since the last LOAD/CLEAR/wrap.
- frame_done  output  1  one-cycle pulse after the Nth shift.

Behaviour:
- Reset: rst_n=0 asynchronously forces q='0, shift_cnt=0, frame_done=0. This holds mid-frame too; no operation in progress survives reset.
- All state updates on the rising clk edge, only when en=1. en=0: q and shift_cnt hold; frame_done=0 on the next edge.
- Modes, applied with en=1:
  - 000 HOLD: q holds.
  - 001 LOAD: q<=parallel_in.
  - 010 SHR: q<={serial_in_l, q[N-1:1]}.
  - 011 SHL: q<={q[N-2:0], serial_in_r}.
  - 100 ROR: q<={q[0], q[N-1:1]}.
  - 101 ROL: q<={q[N-2:0], q[N-1]}.
  - 110 ASR: q<={q[N-1], q[N-1:1]}, sign preserved; serial_in_l ignored.
  - 111 CLEAR: q<='0 synchronously.
- Shift ops are SHR, SHL, ROR, ROL and ASR. Latency is 1 cycle: parallel_out and both serial outputs reflect the op after the edge.
- Counter:
  - LOAD or CLEAR sets shift_cnt<=0.
  - Each shift op increments shift_cnt.
  - When shift_cnt==N-1 and a shift op executes, shift_cnt<=0 (wrap) and frame_done<=1 for exactly one cycle.
  - HOLD leaves shift_cnt unchanged. shift_cnt never reads N.
  - Mixed directions within a frame still count; the counter tracks operations, not data.
- frame_done is registered. It is 0 after any edge that is not the wrapping shift, including edges with en=0.
- Back-to-back frames: continuous shifting pulses frame_done every N cycles, with no gap.
- LOAD on the cycle after a wrap: frame_done is still high for that cycle (from the wrap edge); the counter restarts at 0.
- Outputs are X-free after reset for any known inputs. mode X is not required to be handled.

Decomposition:
- Package usr_pkg:
  - typedef enum logic [2:0] mode_t {MODE_HOLD, MODE_LOAD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR, MODE_CLEAR}.
  - function is_shift(mode_t) returning 1 for SHR/SHL/ROR/ROL/ASR.
- One sub-module, usr_shift_counter, parametrised on N:
  - Inputs: clk, rst_n, inc, clr.
  - Outputs: cnt, wrap_pulse.
  - Top instantiates it with inc=en&is_shift(mode) and clr=en&(mode==LOAD|mode==CLEAR).
- Datapath next-state logic is a single case on mode in the top.

Test Plan:
- Reset: assert rst_n low mid-cycle with q=8'hA5, shift_cnt=3 -> parallel_out=0, shift_cnt=0, frame_done=0 immediately, before any clk edge.
- Load + SHR serialize: LOAD 8'hB4, then 8 SHR with serial_in_l=0 -> serial_out_r sequence before each edge is 0,0,1,0,1,1,0,1. frame_done high only in the cycle after the 8th shift; final q=8'h00, shift_cnt=0.
- Deserialize via SHL: from cleared, 8 SHL with serial_in_r bits 1,0,1,0,0,1,1,1 (first bit first) -> q=8'hA7, frame_done pulses once.
- Rotate/ASR: LOAD 8'h81, ROL -> 8'h03; ROR twice -> 8'hC0; ASR -> 8'hE0. shift_cnt=4 with no frame_done.
- Enable gating: LOAD 8'h3C, then en=0 with mode=SHR for 5 cycles -> q stays 8'h3C, shift_cnt=0. Then CLEAR -> q=0.
- Wrap/restart: 7 SHR, LOAD 8'hFF, 8 SHL -> no pulse after the 7th shift; shift_cnt=0 after the LOAD; frame_done pulses after the 8th SHL. Continue 8 more SHL -> second pulse exactly 8 cycles later.
